// File: rtl/nes_rom_loader.sv
// nes_rom_loader: UART-fed iNES image loader. Synchronises the uart byte strobe,
// validates the 16-byte iNES header, streams PRG then CHR bytes into the ROM write
// ports and holds the CPU/PPU in reset while a load is in progress.
// Optional feature macro: NES_LOADER_CHECKSUM_EN (modulo-256 trailer checksum, CHK state).
module nes_rom_loader #(
  parameter int PRG_LEN = 16384,
  parameter int CHR_LEN = 8192,
  parameter int TIMEOUT = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic [13:0] prg_addr,
  output logic [7:0]  prg_data,
  output logic        prg_wren,
  output logic [12:0] chr_addr,
  output logic [7:0]  chr_data,
  output logic        chr_wren,
  output logic        mirror_v,
  output logic        sys_reset,
  output logic        busy,
  output logic        error
);

  localparam int              CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_MAX    = CW'(TIMEOUT);
  localparam logic [CW-1:0]   TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [13:0]     PRG_LAST  = 14'(PRG_LEN - 1);
  localparam logic [12:0]     CHR_LAST  = 13'(CHR_LEN - 1);
  localparam logic [7:0]      PRG_UNITS = 8'(PRG_LEN / 16384);
  localparam logic [7:0]      CHR_UNITS = 8'(CHR_LEN / 8192);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PRG, S_CHR, S_ERR
`ifdef NES_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, sync3_q, take_q;
  logic [3:0]    hdr_idx_q, hdr_idx_d;
  logic [13:0]   prg_addr_q, prg_addr_d;
  logic [12:0]   chr_addr_q, chr_addr_d;
  logic [7:0]    prg_data_q, prg_data_d, chr_data_q, chr_data_d;
  logic          prg_wren_q, prg_wren_d, chr_wren_q, chr_wren_d;
  logic          mirror_q, mirror_d, error_q, error_d;
  logic [CW-1:0] silence_q, silence_d;
  logic          hdr_ok, timeout, go_err;
`ifdef NES_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  // Bring the uart strobe into clk and turn each rising edge into a single take pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      take_q  <= 1'b0;
    end else begin
      sync1_q <= rx_ready;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      take_q  <= sync2_q & ~sync3_q;
    end
  end

  // Header byte validation for the current header index (idx7..15 are don't-care)
  always_comb begin
    hdr_ok = 1'b1;
    case (hdr_idx_q)
      4'd0:    hdr_ok = (rx_byte == 8'h4E);
      4'd1:    hdr_ok = (rx_byte == 8'h45);
      4'd2:    hdr_ok = (rx_byte == 8'h53);
      4'd3:    hdr_ok = (rx_byte == 8'h1A);
      4'd4:    hdr_ok = (rx_byte == PRG_UNITS);
      4'd5:    hdr_ok = (rx_byte == CHR_UNITS);
      4'd6:    hdr_ok = ~rx_byte[2];
      default: hdr_ok = 1'b1;
    endcase
  end

  // Load sequencer: header parse, ROM streaming, silence timeout and error handling
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = (state_q == S_HDR) ? hdr_idx_q : 4'd0;
    prg_addr_d = prg_addr_q;
    chr_addr_d = chr_addr_q;
    prg_data_d = prg_data_q;
    chr_data_d = chr_data_q;
    prg_wren_d = 1'b0;
    chr_wren_d = 1'b0;
    mirror_d   = mirror_q;
    error_d    = error_q;
    go_err     = 1'b0;
`ifdef NES_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    // Silence counter: cleared by every take, saturates at TIMEOUT, idle outside a load
    if (state_q == S_IDLE || take_q) silence_d = '0;
    else if (silence_q != TO_MAX)     silence_d = silence_q + CW'(1);
    else                              silence_d = silence_q;
    // A take in the same cycle as expiry wins, so expiry is only considered without one
    timeout = ~take_q && (state_q != S_IDLE) && (silence_q >= TO_LAST);

    // Addresses advance the clk after their strobe and stop on the last location
    if (prg_wren_q && prg_addr_q != PRG_LAST) prg_addr_d = prg_addr_q + 14'd1;
    if (chr_wren_q && chr_addr_q != CHR_LAST) chr_addr_d = chr_addr_q + 13'd1;

    case (state_q)
      S_IDLE: if (take_q) begin
        error_d = 1'b0;
`ifdef NES_LOADER_CHECKSUM_EN
        sum_d   = 8'd0;
`endif
        if (hdr_ok) begin
          state_d   = S_HDR;
          hdr_idx_d = 4'd1;
        end else begin
          go_err = 1'b1;
        end
      end
      S_HDR: if (take_q) begin
        if (!hdr_ok) begin
          go_err = 1'b1;
        end else begin
          if (hdr_idx_q == 4'd6) mirror_d = rx_byte[0];
          if (hdr_idx_q == 4'd15) begin
            state_d    = S_PRG;
            prg_addr_d = 14'd0;
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end
      end else if (timeout) go_err = 1'b1;
      S_PRG: if (take_q) begin
        prg_data_d = rx_byte;
        prg_wren_d = 1'b1;
`ifdef NES_LOADER_CHECKSUM_EN
        sum_d      = sum_q + rx_byte;
`endif
        if (prg_addr_q == PRG_LAST) begin
          state_d    = S_CHR;
          chr_addr_d = 13'd0;
        end
      end else if (timeout) go_err = 1'b1;
      S_CHR: if (take_q) begin
        chr_data_d = rx_byte;
        chr_wren_d = 1'b1;
`ifdef NES_LOADER_CHECKSUM_EN
        sum_d      = sum_q + rx_byte;
        if (chr_addr_q == CHR_LAST) state_d = S_CHK;
`else
        if (chr_addr_q == CHR_LAST) state_d = S_IDLE;
`endif
      end else if (timeout) go_err = 1'b1;
`ifdef NES_LOADER_CHECKSUM_EN
      S_CHK: if (take_q) begin
        if (rx_byte == sum_q) state_d = S_IDLE;
        else                  go_err  = 1'b1;
      end else if (timeout) go_err = 1'b1;
`endif
      S_ERR: if (timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Entering ERR restarts the silence count so the release delay is measured from here
    if (go_err) begin
      state_d   = S_ERR;
      error_d   = 1'b1;
      silence_d = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= 4'd0;
      prg_addr_q <= 14'd0;
      chr_addr_q <= 13'd0;
      prg_data_q <= 8'd0;
      chr_data_q <= 8'd0;
      prg_wren_q <= 1'b0;
      chr_wren_q <= 1'b0;
      mirror_q   <= 1'b0;
      error_q    <= 1'b0;
      silence_q  <= '0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      prg_addr_q <= prg_addr_d;
      chr_addr_q <= chr_addr_d;
      prg_data_q <= prg_data_d;
      chr_data_q <= chr_data_d;
      prg_wren_q <= prg_wren_d;
      chr_wren_q <= chr_wren_d;
      mirror_q   <= mirror_d;
      error_q    <= error_d;
      silence_q  <= silence_d;
    end
  end

`ifdef NES_LOADER_CHECKSUM_EN
  // Running modulo-256 sum of all PRG and CHR bytes
  always_ff @(posedge clk) begin
    if (reset) sum_q <= 8'd0;
    else       sum_q <= sum_d;
  end
`endif

  // Status outputs decoded from the registered state
  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_HDR, S_PRG, S_CHR: busy = 1'b1;
`ifdef NES_LOADER_CHECKSUM_EN
      S_CHK:               busy = 1'b1;
`endif
      default:             busy = 1'b0;
    endcase
    sys_reset = (state_q != S_IDLE);
  end

  assign prg_addr = prg_addr_q;
  assign prg_data = prg_data_q;
  assign prg_wren = prg_wren_q;
  assign chr_addr = chr_addr_q;
  assign chr_data = chr_data_q;
  assign chr_wren = chr_wren_q;
  assign mirror_v = mirror_q;
  assign error    = error_q;

endmodule
